// File: rtl/llc_bus_responder.sv
// Shared-bus responder: accepts one LLC bus operation at a time, broadcasts it
// as a snoop, combines peer results and returns a one-cycle completion.
module llc_bus_responder #(
    parameter int ADDR_W      = 32,
    parameter int NUM_PEERS   = 3,
    parameter int BYTE_OFFSET = 6,
    parameter int MEM_LAT     = 4,
    parameter int SNOOP_TMO   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   snoop_valid,
    output logic [2:0]             snoop_op,
    output logic [ADDR_W-1:0]      snoop_addr,
    input  logic [NUM_PEERS-1:0]   peer_result_valid,
    input  logic [2*NUM_PEERS-1:0] peer_result,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_result,
    output logic                   rsp_src,
    output logic [31:0]            txn_count,
    output logic [31:0]            hitm_count,
    output logic                   err
);

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    localparam logic [1:0] RES_HIT      = 2'd0;
    localparam logic [1:0] RES_HITM     = 2'd1;
    localparam logic [1:0] RES_NOHIT    = 2'd2;
    localparam logic [1:0] RES_NORESULT = 2'd3;

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int TMO_W = $clog2(SNOOP_TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        MEM,
        WB,
        RESP
    } state_t;

    state_t                 state;
    logic [2:0]             op_q;
    logic [NUM_PEERS-1:0]   mask;
    logic [2*NUM_PEERS-1:0] res;
    logic [TMO_W-1:0]       wait_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [1:0]             comb_q;

    logic [NUM_PEERS-1:0]   mask_nxt;
    logic [2*NUM_PEERS-1:0] res_nxt;
    logic                   any_hitm;
    logic                   multi_hitm;
    logic                   any_hit;
    logic [1:0]             comb;
    logic                   all_in;
    logic                   tmo;

    // Results including this cycle's strobes; only the first strobe per peer
    // is captured, and peers still missing are treated as NOHIT.
    always_comb begin
        mask_nxt   = mask | peer_result_valid;
        res_nxt    = res;
        any_hitm   = 1'b0;
        multi_hitm = 1'b0;
        any_hit    = 1'b0;
        for (int i = 0; i < NUM_PEERS; i++) begin
            if (peer_result_valid[i] && !mask[i])
                res_nxt[2*i +: 2] = peer_result[2*i +: 2];
            if (mask_nxt[i] && res_nxt[2*i +: 2] == RES_HITM) begin
                if (any_hitm)
                    multi_hitm = 1'b1;
                any_hitm = 1'b1;
            end
            if (mask_nxt[i] && res_nxt[2*i +: 2] == RES_HIT)
                any_hit = 1'b1;
        end
        if (any_hitm)
            comb = RES_HITM;
        else if (any_hit)
            comb = RES_HIT;
        else
            comb = RES_NOHIT;
        all_in = &mask_nxt;
        // wait_cnt is 0 in the first WAIT cycle, so the timeout lands in the
        // cycle where it has counted up to SNOOP_TMO.
        tmo    = (wait_cnt == TMO_W'(SNOOP_TMO));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            snoop_valid <= 1'b0;
            snoop_op    <= 3'd0;
            snoop_addr  <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= RES_NORESULT;
            rsp_src     <= 1'b0;
            txn_count   <= '0;
            hitm_count  <= '0;
            err         <= 1'b0;
            op_q        <= 3'd0;
            mask        <= '0;
            res         <= '0;
            wait_cnt    <= '0;
            lat_cnt     <= '0;
            comb_q      <= RES_NOHIT;
        end else begin
            snoop_valid <= 1'b0;
            rsp_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        mask      <= '0;
                        wait_cnt  <= '0;
                        rsp_src   <= 1'b0;
                        case (req_op)
                            OP_WRITE: begin
                                state     <= MEM;
                                lat_cnt   <= LAT_W'(MEM_LAT);
                                txn_count <= txn_count + 32'd1;
                            end
                            OP_READ, OP_INV, OP_RWIM: begin
                                state       <= ISSUE;
                                snoop_valid <= 1'b1;
                                snoop_op    <= req_op;
                                snoop_addr  <= {req_addr[ADDR_W-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
                                txn_count   <= txn_count + 32'd1;
                            end
                            default: begin
                                state      <= RESP;
                                rsp_valid  <= 1'b1;
                                rsp_result <= RES_NORESULT;
                            end
                        endcase
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    mask     <= mask_nxt;
                    res      <= res_nxt;
                    wait_cnt <= wait_cnt + 1'b1;
                    if (all_in || tmo) begin
                        if ((tmo && !all_in) || multi_hitm)
                            err <= 1'b1;
                        comb_q <= comb;
                        if (op_q == OP_INV) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= comb;
                        end else begin
                            state   <= (comb == RES_HITM) ? WB : MEM;
                            rsp_src <= (comb == RES_HITM);
                            lat_cnt <= LAT_W'(MEM_LAT);
                        end
                    end
                end
                MEM, WB: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= (op_q == OP_WRITE) ? RES_NORESULT : comb_q;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    if (rsp_result == RES_HITM)
                        hitm_count <= hitm_count + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
